// File: rtl/waterfall_pkg.sv
// Shared types and constants for the waterfall column scheduler.
// Optional column statistics are enabled with the WATERFALL_COL_STATS_EN macro.
package waterfall_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BURST_LOW  = 2'd1,
        BURST_HIGH = 2'd2
    } state_t;

    localparam logic SEL_LOW  = 1'b0;
    localparam logic SEL_HIGH = 1'b1;

    localparam int SAMPLE_W = 16;

endpackage

// File: rtl/waterfall_column_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie, the requester not granted last wins.
module rr_arbiter2
    import waterfall_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == SEL_HIGH) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/waterfall_column_scheduler.sv
// Burst-locked round-robin sharing of one framebuffer write port between two column streams.
// Define WATERFALL_COL_STATS_EN to get per-stream completed-column counters.
module waterfall_column_scheduler
    import waterfall_pkg::*;
#(
    parameter int COLUMN_LEN  = 256,
    parameter int NUM_COLUMNS = 64
) (
    input  logic                           clk_data,
    input  logic                           reset,
    input  logic                           low_sink_valid,
    input  logic [SAMPLE_W-1:0]            low_sink_data,
    output logic                           low_sink_ready,
    input  logic                           high_sink_valid,
    input  logic [SAMPLE_W-1:0]            high_sink_data,
    output logic                           high_sink_ready,
    output logic                           wr_en,
    output logic                           wr_sel,
    output logic [$clog2(COLUMN_LEN)-1:0]  wr_addr,
    output logic [SAMPLE_W-1:0]            wr_data,
    output logic                           column_done,
    output logic                           column_done_sel,
    output logic [$clog2(NUM_COLUMNS)-1:0] low_col_ptr,
    output logic [$clog2(NUM_COLUMNS)-1:0] high_col_ptr,
    output logic [15:0]                    low_col_count,
    output logic [15:0]                    high_col_count
);

    localparam int ADDR_W = $clog2(COLUMN_LEN);
    localparam int PTR_W  = $clog2(NUM_COLUMNS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COLUMN_LEN - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic                last_grant;
    logic [1:0]          grant;
    logic                acc;
    logic                acc_sel;
    logic [SAMPLE_W-1:0] acc_data;
    logic                col_end;

    rr_arbiter2 u_arb (
        .req        ({high_sink_valid, low_sink_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready depends only on the registered state, never on valid.
    assign low_sink_ready  = (state == BURST_LOW);
    assign high_sink_ready = (state == BURST_HIGH);

    always_comb begin
        acc_sel  = (state == BURST_HIGH) ? SEL_HIGH : SEL_LOW;
        acc      = (low_sink_valid && low_sink_ready) || (high_sink_valid && high_sink_ready);
        acc_data = (acc_sel == SEL_HIGH) ? high_sink_data : low_sink_data;
        col_end  = acc && (idx == LAST_IDX);
    end

    always_ff @(posedge clk_data) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            last_grant      <= SEL_HIGH;
            wr_en           <= 1'b0;
            wr_sel          <= SEL_LOW;
            wr_addr         <= '0;
            wr_data         <= '0;
            column_done     <= 1'b0;
            column_done_sel <= SEL_LOW;
            low_col_ptr     <= '0;
            high_col_ptr    <= '0;
        end else begin
            wr_en       <= acc;
            column_done <= 1'b0;
            if (acc) begin
                wr_sel  <= acc_sel;
                wr_addr <= idx;
                wr_data <= acc_data;
                idx     <= idx + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        state <= BURST_LOW;
                    end else if (grant[1]) begin
                        state <= BURST_HIGH;
                    end
                end
                BURST_LOW, BURST_HIGH: begin
                    // Last sample of the column: release the lock and advance the scroll origin.
                    if (col_end) begin
                        state           <= IDLE;
                        last_grant      <= acc_sel;
                        column_done     <= 1'b1;
                        column_done_sel <= acc_sel;
                        if (acc_sel == SEL_HIGH) begin
                            high_col_ptr <= high_col_ptr + PTR_W'(1);
                        end else begin
                            low_col_ptr <= low_col_ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WATERFALL_COL_STATS_EN
    always_ff @(posedge clk_data) begin
        if (reset) begin
            low_col_count  <= 16'd0;
            high_col_count <= 16'd0;
        end else if (col_end) begin
            if (acc_sel == SEL_HIGH) begin
                high_col_count <= high_col_count + 16'd1;
            end else begin
                low_col_count <= low_col_count + 16'd1;
            end
        end
    end
`else
    assign low_col_count  = 16'd0;
    assign high_col_count = 16'd0;
`endif

endmodule

// File: tb/tb_waterfall_column_scheduler.sv
// Self-checking bench for waterfall_column_scheduler with COLUMN_LEN = 4, NUM_COLUMNS = 4.
module tb_waterfall_column_scheduler;

    localparam int CL = 4;
    localparam int NC = 4;
`ifdef WATERFALL_COL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        low_sink_valid = 1'b0;
    logic [15:0] low_sink_data = 16'd0;
    logic        low_sink_ready;
    logic        high_sink_valid = 1'b0;
    logic [15:0] high_sink_data = 16'd0;
    logic        high_sink_ready;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        column_done;
    logic        column_done_sel;
    logic [1:0]  low_col_ptr;
    logic [1:0]  high_col_ptr;
    logic [15:0] low_col_count;
    logic [15:0] high_col_count;

    int checks = 0;
    int errors = 0;

    waterfall_column_scheduler #(.COLUMN_LEN(CL), .NUM_COLUMNS(NC)) dut (
        .clk_data        (clk),
        .reset           (reset),
        .low_sink_valid  (low_sink_valid),
        .low_sink_data   (low_sink_data),
        .low_sink_ready  (low_sink_ready),
        .high_sink_valid (high_sink_valid),
        .high_sink_data  (high_sink_data),
        .high_sink_ready (high_sink_ready),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .column_done     (column_done),
        .column_done_sel (column_done_sel),
        .low_col_ptr     (low_col_ptr),
        .high_col_ptr    (high_col_ptr),
        .low_col_count   (low_col_count),
        .high_col_count  (high_col_count)
    );

    always #5 clk = ~clk;

    // Reference model: owner of the port (-1 none), position in column, last winner.
    int          m_owner;
    int          m_pos;
    int          m_last;
    int          m_ptr [2];
    int          m_cnt [2];
    logic        e_wr_en, e_done, e_sel, e_done_sel;
    logic [1:0]  e_addr;
    logic [15:0] e_data;

    function automatic logic [15:0] exp_cnt(int s);
        return STATS ? 16'(m_cnt[s]) : 16'd0;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_pos = 0; m_last = 1;
        m_ptr[0] = 0; m_ptr[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        e_wr_en = 0; e_done = 0; e_sel = 0; e_done_sel = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            e_wr_en = 0;
            e_done  = 0;
            if (m_owner < 0) begin
                if (low_sink_valid && high_sink_valid) m_owner = 1 - m_last;
                else if (low_sink_valid)                m_owner = 0;
                else if (high_sink_valid)               m_owner = 1;
            end else if ((m_owner == 0 && low_sink_valid) || (m_owner == 1 && high_sink_valid)) begin
                e_wr_en = 1;
                e_sel   = 1'(m_owner);
                e_addr  = 2'(m_pos);
                e_data  = (m_owner == 1) ? high_sink_data : low_sink_data;
                m_pos++;
                if (m_pos == CL) begin
                    e_done        = 1;
                    e_done_sel    = 1'(m_owner);
                    m_last        = m_owner;
                    m_ptr[m_owner] = (m_ptr[m_owner] + 1) % NC;
                    m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
                    m_owner       = -1;
                    m_pos         = 0;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1; low_sink_valid = 0; high_sink_valid = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; low_sink_valid = 1; high_sink_valid = 1;
        tick(); tick();
        checks++;
        if ({low_sink_ready, high_sink_ready, wr_en, wr_sel, wr_addr, wr_data, column_done,
             column_done_sel, low_col_ptr, high_col_ptr, low_col_count, high_col_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b%b wr_en=%b sel=%b addr=%0d data=%h done=%b/%b ptr=%0d/%0d cnt=%0d/%0d, all required 0",
                     low_sink_ready, high_sink_ready, wr_en, wr_sel, wr_addr, wr_data, column_done,
                     column_done_sel, low_col_ptr, high_col_ptr, low_col_count, high_col_count);
        end
        reset = 0; low_sink_valid = 0; high_sink_valid = 0;
        tick();
        checks++;
        if ({low_sink_ready, high_sink_ready, wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b%b wr_en=%b, required 000", low_sink_ready, high_sink_ready, wr_en);
        end
    endtask

    task automatic test_single_low();
        apply_reset();
        low_sink_valid = 1; low_sink_data = 16'hA000;
        checks++;
        if (low_sink_ready !== 1'b0) begin
            errors++; $display("FAIL single_idle_ready: got %b required 0", low_sink_ready);
        end
        tick();
        checks++;
        if ({low_sink_ready, high_sink_ready, wr_en} !== 3'b100) begin
            errors++; $display("FAIL single_grant: ready=%b%b wr_en=%b required 1 0 0", low_sink_ready, high_sink_ready, wr_en);
        end
        for (int k = 0; k < CL; k++) begin
            low_sink_data = 16'hA000 + 16'(k);
            tick();
            checks++;
            if ({wr_en, wr_sel, wr_addr, wr_data, column_done, low_col_ptr} !==
                {1'b1, 1'b0, 2'(k), 16'hA000 + 16'(k), (k == CL - 1), (k == CL - 1) ? 2'd1 : 2'd0}) begin
                errors++;
                $display("FAIL single_write_%0d: en=%b sel=%b addr=%0d data=%h done=%b ptr=%0d, required 1 0 %0d %h %b %0d",
                         k, wr_en, wr_sel, wr_addr, wr_data, column_done, low_col_ptr,
                         k, 16'hA000 + 16'(k), (k == CL - 1), (k == CL - 1) ? 1 : 0);
            end
        end
        checks++;
        if ({low_sink_ready, column_done_sel, low_col_count} !== {1'b0, 1'b0, exp_cnt(0)}) begin
            errors++; $display("FAIL single_end: ready=%b done_sel=%b cnt=%0d required 0 0 %0d",
                               low_sink_ready, column_done_sel, low_col_count, exp_cnt(0));
        end
        low_sink_valid = 0;
        tick();
    endtask

    task automatic test_alternate();
        logic done_q[$];
        apply_reset();
        low_sink_valid = 1; high_sink_valid = 1;
        for (int c = 0; c < 4 * (CL + 1); c++) begin
            low_sink_data = 16'($urandom); high_sink_data = 16'($urandom);
            tick();
            checks++;
            if ({low_sink_ready, high_sink_ready, wr_en} !== {m_owner == 0, m_owner == 1, e_wr_en}) begin
                errors++; $display("FAIL alt_cycle_%0d: ready=%b%b wr_en=%b required %b%b %b", c,
                                   low_sink_ready, high_sink_ready, wr_en, m_owner == 0, m_owner == 1, e_wr_en);
            end
            if (e_wr_en) begin
                checks++;
                if ({wr_sel, wr_addr, wr_data} !== {e_sel, e_addr, e_data}) begin
                    errors++; $display("FAIL alt_write_%0d: sel=%b addr=%0d data=%h required %b %0d %h",
                                       c, wr_sel, wr_addr, wr_data, e_sel, e_addr, e_data);
                end
            end
            if (column_done) done_q.push_back(column_done_sel);
        end
        checks++;
        if (done_q.size() != 4 || done_q[0] !== 1'b0 || done_q[1] !== 1'b1 || done_q[2] !== 1'b0 || done_q[3] !== 1'b1) begin
            errors++; $display("FAIL alt_order: %0d columns, sels %p, required 4 columns 0 1 0 1", done_q.size(), done_q);
        end
        low_sink_valid = 0; high_sink_valid = 0;
    endtask

    task automatic test_stall();
        apply_reset();
        low_sink_valid = 1; high_sink_valid = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            low_sink_data = 16'hA000 + 16'(k);
            tick();
        end
        low_sink_valid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({wr_en, low_sink_ready, high_sink_ready} !== 3'b010) begin
                errors++; $display("FAIL stall_%0d: wr_en=%b ready=%b%b required 0 1 0", k, wr_en, low_sink_ready, high_sink_ready);
            end
        end
        low_sink_valid = 1; low_sink_data = 16'hA002;
        tick();
        checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, column_done} !== {1'b1, 1'b0, 2'd2, 16'hA002, 1'b0}) begin
            errors++; $display("FAIL stall_resume: en=%b sel=%b addr=%0d data=%h done=%b required 1 0 2 a002 0",
                               wr_en, wr_sel, wr_addr, wr_data, column_done);
        end
        low_sink_data = 16'hA003;
        tick();
        checks++;
        if ({wr_addr, column_done, high_sink_ready} !== {2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL stall_last: addr=%0d done=%b high_ready=%b required 3 1 0", wr_addr, column_done, high_sink_ready);
        end
        tick();
        checks++;
        if ({low_sink_ready, high_sink_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_next_grant: ready=%b%b required 0 1", low_sink_ready, high_sink_ready);
        end
        low_sink_valid = 0; high_sink_valid = 0;
    endtask

    task automatic test_wrap();
        int ndone = 0;
        apply_reset();
        high_sink_valid = 1;
        for (int c = 0; c < 10 * (CL + 1); c++) begin
            high_sink_data = 16'($urandom);
            tick();
            if (column_done) begin
                ndone++;
                checks++;
                if ({column_done_sel, high_col_ptr} !== {1'b1, 2'(ndone % NC)}) begin
                    errors++; $display("FAIL wrap_col_%0d: sel=%b ptr=%0d required 1 %0d", ndone, column_done_sel, high_col_ptr, ndone % NC);
                end
            end
            if (ndone == 4) break;
        end
        checks++;
        if (ndone != 4) begin
            errors++; $display("FAIL wrap_timeout: %0d columns completed, required 4", ndone);
        end
        checks++;
        if ({high_col_ptr, high_col_count, low_col_ptr, low_col_count} !== {2'd0, STATS ? 16'd4 : 16'd0, 2'd0, 16'd0}) begin
            errors++; $display("FAIL wrap_final: hptr=%0d hcnt=%0d lptr=%0d lcnt=%0d required 0 %0d 0 0",
                               high_col_ptr, high_col_count, low_col_ptr, low_col_count, STATS ? 4 : 0);
        end
        high_sink_valid = 0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        low_sink_valid = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            low_sink_data = 16'hA000 + 16'(k);
            tick();
        end
        reset = 1;
        tick();
        checks++;
        if ({column_done, wr_en, low_sink_ready, low_col_ptr} !== 5'b0) begin
            errors++; $display("FAIL midrst_in_reset: done=%b wr_en=%b ready=%b ptr=%0d required all 0",
                               column_done, wr_en, low_sink_ready, low_col_ptr);
        end
        reset = 0; low_sink_valid = 1; high_sink_valid = 1;
        tick();
        checks++;
        if ({low_sink_ready, high_sink_ready, column_done} !== 3'b100) begin
            errors++; $display("FAIL midrst_tie: ready=%b%b done=%b required 1 0 0", low_sink_ready, high_sink_ready, column_done);
        end
        for (int k = 0; k < CL; k++) begin
            low_sink_data = 16'hB000 + 16'(k);
            tick();
            checks++;
            if ({wr_en, wr_sel, wr_addr, wr_data, column_done, low_col_ptr} !==
                {1'b1, 1'b0, 2'(k), 16'hB000 + 16'(k), (k == CL - 1), (k == CL - 1) ? 2'd1 : 2'd0}) begin
                errors++; $display("FAIL midrst_write_%0d: en=%b sel=%b addr=%0d data=%h done=%b ptr=%0d, required 1 0 %0d %h %b",
                                   k, wr_en, wr_sel, wr_addr, wr_data, column_done, low_col_ptr,
                                   k, 16'hB000 + 16'(k), (k == CL - 1));
            end
        end
        low_sink_valid = 0; high_sink_valid = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            low_sink_valid  = ($urandom_range(0, 9) < 7);
            high_sink_valid = ($urandom_range(0, 9) < 6);
            low_sink_data   = 16'($urandom);
            high_sink_data  = 16'($urandom);
            reset           = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if ({low_sink_ready, high_sink_ready, wr_en, column_done} !== {m_owner == 0, m_owner == 1, e_wr_en, e_done}) begin
                errors++; $display("FAIL rand_ctrl_%0d: ready=%b%b wr_en=%b done=%b required %b%b %b %b", c,
                                   low_sink_ready, high_sink_ready, wr_en, column_done, m_owner == 0, m_owner == 1, e_wr_en, e_done);
            end
            if (e_wr_en) begin
                checks++;
                if ({wr_sel, wr_addr, wr_data} !== {e_sel, e_addr, e_data}) begin
                    errors++; $display("FAIL rand_write_%0d: sel=%b addr=%0d data=%h required %b %0d %h",
                                       c, wr_sel, wr_addr, wr_data, e_sel, e_addr, e_data);
                end
            end
            if (e_done) begin
                checks++;
                if (column_done_sel !== e_done_sel) begin
                    errors++; $display("FAIL rand_done_sel_%0d: got %b required %b", c, column_done_sel, e_done_sel);
                end
            end
            checks++;
            if ({low_col_ptr, high_col_ptr, low_col_count, high_col_count} !==
                {2'(m_ptr[0]), 2'(m_ptr[1]), exp_cnt(0), exp_cnt(1)}) begin
                errors++; $display("FAIL rand_ptr_%0d: ptr=%0d/%0d cnt=%0d/%0d required %0d/%0d %0d/%0d", c,
                                   low_col_ptr, high_col_ptr, low_col_count, high_col_count,
                                   m_ptr[0], m_ptr[1], exp_cnt(0), exp_cnt(1));
            end
        end
        reset = 0; low_sink_valid = 0; high_sink_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_low();
        test_alternate();
        test_stall();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
